stream_half_fifo: RTL and testbench
===================================

Name: stream_half_fifo

Overview:
- Single-clock sample FIFO feeding the DAC-side interpolation stage.
- Buffers unsigned DATA_WIDTH samples from the filter/Costas path.
- Raises a sticky stream-enable once occupancy first reaches half depth. The downstream stage ties that enable straight to its read request and reads continuously.
- Detects underflow and overflow. On underflow it re-arms, re-fills to half, then resumes streaming.

Parameters:
- DATA_WIDTH, 14: sample width, unsigned.
- ADDR_WIDTH, 10: log2 of depth; DEPTH = 2**ADDR_WIDTH = 1024.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write request from upstream.
- din  input  DATA_WIDTH  write data, unsigned.
- full  output  1  occupancy == DEPTH.
- rd_en  input  1  read request from downstream.
- dout  output  DATA_WIDTH  read data, unsigned, registered.
- dout_valid  output  1  one-cycle pulse; dout updated this cycle.
- empty  output  1  occupancy == 0.
- above_half  output  1  sticky stream enable; drives the downstream ena.
- count  output  ADDR_WIDTH+1  current occupancy.
- underflow  output  1  sticky error flag.
- overflow  output  1  sticky error flag.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Pointers and count = 0; empty=1, full=0.
  - dout=0, dout_valid=0, above_half=0, underflow=0, overflow=0.
  - State = FILL. Reset takes priority over all activity in the same cycle; in-flight data is discarded.
- Write accept: wr_en && !full, with full sampled before the edge. Stores din at wr_ptr; wr_ptr increments modulo DEPTH.
- Write drop: wr_en && full. No storage; sets overflow.
- Read accept: rd_en && !empty. Reads mem[rd_ptr] into dout on the next edge; dout_valid=1 for that one cycle. rd_ptr wraps modulo DEPTH.
- Read fail: rd_en && empty. No pointer change; dout holds; dout_valid=0.
- Read latency: 1 cycle from the accepted rd_en edge to dout/dout_valid.
- dout holds its value when no read is accepted.
- Count update: count += write_accept − read_accept.
  - Simultaneous accepted read and write leave count unchanged.
  - Flags full, empty and count are registered and consistent with each other every cycle.
- State machine (above_half = (state == STREAM)):
  - FILL -> STREAM when the next-cycle count ≥ DEPTH/2. above_half rises in the same cycle count first shows ≥ 512.
  - STREAM stays in STREAM regardless of count dropping below half (hysteresis; continuous transmission).
  - STREAM -> FILL on a read fail: rd_en && empty. That cycle sets underflow; above_half drops the next cycle.
  - rd_en while in FILL is honoured normally (read accept / fail rules apply) but does not set underflow.
- Sticky flags: underflow and overflow clear only on rst.
- Wrap-around: pointers are ADDR_WIDTH bits. Full/empty come from count, not pointer compare.

Optional Feature:
- Macro: STREAM_HALF_FIFO_STATS_EN.
- Defined:
  - Adds outputs ovf_cnt[15:0] and udf_cnt[15:0].
  - They count dropped writes and read fails in STREAM respectively.
  - Both saturate at 16'hFFFF and reset to 0 on rst.
- Undefined: the ports and counters do not exist. Sticky flags are unaffected either way.

Decomposition:
- Shared package holds:
  - state encoding typedef (FILL, STREAM);
  - DEPTH/HALF-derivation localparams;
  - counter saturation constant CNT_MAX.
- One natural sub-module: sync_ram_1r1w. Simple dual-port DATA_WIDTH x DEPTH memory with registered read port, inferable as block RAM.
- Control, flags and FSM stay in the top.

Test Plan:
- Reset/fill:
  - After rst, write 511 samples 0..510 with rd_en=0 -> above_half=0, count=511.
  - Write the 512th sample (511) -> above_half=1 in the same cycle count shows 512.
- Stream order:
  - Tie rd_en=above_half; continue writing 1 sample/cycle.
  - dout sequence is 0,1,2,... each with dout_valid pulse 1 cycle after the accepted read.
  - count stays 512; no flags set.
- Underflow re-arm:
  - In STREAM stop writing; after 512 reads empty=1.
  - The next rd_en sets underflow=1; above_half=0 the following cycle.
  - Refill 512 -> above_half=1 again.
- Overflow:
  - With rd_en=0 write 1030 samples -> full=1 at 1024, overflow=1.
  - Reading back yields samples 0..1023 only.
- Simultaneous at boundary:
  - At count=1024, wr_en=rd_en=1 -> write dropped (overflow=1), read accepted, count=1023.
  - At count=0, wr_en=rd_en=1 -> write accepted, read fail, count=1.
- Reset mid-operation:
  - Assert rst during STREAM with count=300 -> next cycle count=0, above_half=0, dout=0, flags cleared.
  - With STREAM_HALF_FIFO_STATS_EN, ovf_cnt and udf_cnt = 0.

Source files
------------

// File: rtl/stream_half_fifo_pkg.sv
// Shared definitions for the stream_half_fifo block.
//
// Contents:
//   fifo_state_e  : controller state (FILL while priming, STREAM while the
//                   downstream stage is reading continuously).
//   DEF_*         : default data/address widths.
//   CNT_MAX       : saturation value of the optional event counters.
//   depth_of()    : FIFO depth for a given address width.
//   half_of()     : half-depth streaming threshold for a given address width.
package stream_half_fifo_pkg;

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } fifo_state_e;

    localparam int DEF_DATA_WIDTH = 14;
    localparam int DEF_ADDR_WIDTH = 10;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic int half_of(input int addr_width);
        return 1 << (addr_width - 1);
    endfunction

endpackage

// File: rtl/sync_ram_1r1w.sv
// Simple dual-port memory, one write port and one registered read port,
// written so synthesis maps it onto block RAM.
//
// Ports:
//   clk    : clock, rising edge
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   re     : read enable; rdata updates only when re is high
//   raddr  : read address
//   rdata  : registered read data (holds when re is low)
module sync_ram_1r1w
    import stream_half_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:depth_of(ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/stream_half_fifo.sv
// Single-clock sample FIFO in front of the DAC-side interpolation stage.
// Streaming is enabled (above_half) once occupancy first reaches half depth
// and stays enabled until the reader hits an empty FIFO; the block then
// re-primes to half depth before streaming again.
//
// Handshake: a write is accepted on a rising edge when wr_en=1 and full=0;
// a read is accepted when rd_en=1 and empty=0. full/empty are the values
// visible before that edge. An accepted read presents its sample on dout
// with a one-cycle dout_valid pulse after the edge. Rejected requests have
// no effect on storage or pointers.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   wr_en, din      : write request and sample
//   full            : occupancy == DEPTH
//   rd_en           : read request
//   dout, dout_valid: registered read data and its one-cycle valid pulse
//   empty           : occupancy == 0
//   above_half      : sticky stream enable (state == STREAM)
//   count           : current occupancy
//   underflow       : sticky, read attempted on empty FIFO while streaming
//   overflow        : sticky, write attempted on full FIFO
//   ovf_cnt, udf_cnt: saturating event counters, only with the macro
//                     STREAM_HALF_FIFO_STATS_EN defined
module stream_half_fifo
    import stream_half_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  empty,
    output logic                  above_half,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  underflow,
    output logic                  overflow
`ifdef STREAM_HALF_FIFO_STATS_EN
    ,
    output logic [15:0]           ovf_cnt,
    output logic [15:0]           udf_cnt
`endif
);

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(depth_of(ADDR_WIDTH));
    localparam logic [ADDR_WIDTH:0] HALF_CNT  = (ADDR_WIDTH+1)'(half_of(ADDR_WIDTH));

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_next;
    fifo_state_e           state_q;
    fifo_state_e           state_d;
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  dout_zero;

    logic wr_acc;
    logic wr_drop;
    logic rd_acc;
    logic rd_fail;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;

    assign wr_acc  = wr_en && !full;
    assign wr_drop = wr_en && full;
    assign rd_acc  = rd_en && !empty;
    assign rd_fail = rd_en && empty;

    assign count_next = count_q + {{ADDR_WIDTH{1'b0}}, wr_acc}
                                - {{ADDR_WIDTH{1'b0}}, rd_acc};

    assign above_half = (state_q == STREAM);

    // The RAM output register has no reset, so dout is forced to zero from
    // reset until the first accepted read loads a real sample.
    assign dout = dout_zero ? '0 : ram_q;

    sync_ram_1r1w #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc && !rst),
        .waddr (wr_ptr),
        .wdata (din),
        .re    (rd_acc && !rst),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    // Stream enable has hysteresis: once streaming, only a read on an empty
    // FIFO drops back to FILL.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (count_next >= HALF_CNT) state_d = STREAM;
            STREAM:  if (rd_fail)                state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            dout_valid <= 1'b0;
            dout_zero  <= 1'b1;
            underflow  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_next;
            dout_valid <= rd_acc;
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) begin
                rd_ptr    <= rd_ptr + 1'b1;
                dout_zero <= 1'b0;
            end
            if (wr_drop)                      overflow  <= 1'b1;
            if (rd_fail && state_q == STREAM) underflow <= 1'b1;
        end
    end

`ifdef STREAM_HALF_FIFO_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt <= '0;
            udf_cnt <= '0;
        end else begin
            if (wr_drop && ovf_cnt != CNT_MAX) ovf_cnt <= ovf_cnt + 16'd1;
            if (rd_fail && state_q == STREAM && udf_cnt != CNT_MAX)
                udf_cnt <= udf_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_half_fifo.sv
// Bench for stream_half_fifo: directed fill/stream/underflow/overflow
// sequences plus randomized traffic, all checked every cycle against a
// queue-based reference model.
module tb_stream_half_fifo;

  localparam int DW    = 14;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;
  localparam int HALF  = 512;

  // ---------------- clock / reset block ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          full, empty, dout_valid, above_half, underflow, overflow;
  logic [DW-1:0] dout;
  logic [AW:0]   count;
`ifdef STREAM_HALF_FIFO_STATS_EN
  logic [15:0]   ovf_cnt, udf_cnt;
`endif

  always #5 clk = ~clk;

  stream_half_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .din        (din),
    .full       (full),
    .rd_en      (rd_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .empty      (empty),
    .above_half (above_half),
    .count      (count),
    .underflow  (underflow),
    .overflow   (overflow)
`ifdef STREAM_HALF_FIFO_STATS_EN
    ,
    .ovf_cnt    (ovf_cnt),
    .udf_cnt    (udf_cnt)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  logic [DW-1:0] exp_q[$];
  bit            m_stream;
  bit            m_dv;
  bit            m_udf;
  bit            m_ovf;
  logic [DW-1:0] m_dout;
  int            m_ovf_cnt;
  int            m_udf_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_stream  = 0;
    m_dv      = 0;
    m_udf     = 0;
    m_ovf     = 0;
    m_dout    = '0;
    m_ovf_cnt = 0;
    m_udf_cnt = 0;
  endtask

  // One clock edge of the FIFO described purely in terms of occupancy.
  task automatic model_edge(input bit w, input logic [DW-1:0] d, input bit r);
    bit was_full  = (exp_q.size() == DEPTH);
    bit was_empty = (exp_q.size() == 0);
    m_dv = 0;
    if (r && !was_empty) begin
      m_dout = exp_q.pop_front();
      m_dv   = 1;
    end
    if (w && !was_full) exp_q.push_back(d);
    if (w && was_full) begin
      m_ovf = 1;
      if (m_ovf_cnt < 65535) m_ovf_cnt++;
    end
    if (r && was_empty && m_stream) begin
      m_udf    = 1;
      m_stream = 0;
      if (m_udf_cnt < 65535) m_udf_cnt++;
    end else if (!m_stream && exp_q.size() >= HALF) begin
      m_stream = 1;
    end
  endtask

  task automatic check_all();
    check_val("count",      32'(count),      32'(exp_q.size()));
    check_val("full",       32'(full),       32'(exp_q.size() == DEPTH));
    check_val("empty",      32'(empty),      32'(exp_q.size() == 0));
    check_val("above_half", 32'(above_half), 32'(m_stream));
    check_val("dout_valid", 32'(dout_valid), 32'(m_dv));
    check_val("dout",       32'(dout),       32'(m_dout));
    check_val("underflow",  32'(underflow),  32'(m_udf));
    check_val("overflow",   32'(overflow),   32'(m_ovf));
`ifdef STREAM_HALF_FIFO_STATS_EN
    check_val("ovf_cnt",    32'(ovf_cnt),    32'(m_ovf_cnt));
    check_val("udf_cnt",    32'(udf_cnt),    32'(m_udf_cnt));
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r);
    @(negedge clk);
    rst   = 1'b0;
    wr_en = w;
    din   = d;
    rd_en = r;
    @(posedge clk);
    #1;
    model_edge(w, d, r);
    check_all();
  endtask

  // Reset applied together with arbitrary traffic; reset must win.
  task automatic reset_step(input bit w, input bit r);
    @(negedge clk);
    rst   = 1'b1;
    wr_en = w;
    din   = DW'($urandom);
    rd_en = r;
    @(posedge clk);
    #1;
    model_reset();
    check_all();
  endtask

  // ---------------- stimulus ----------------
  logic [DW-1:0] seq;
  int            pw, pr;

  initial begin
    model_reset();

    // reset and prime to one below half
    reset_step(0, 0);
    for (int i = 0; i < HALF - 1; i++) step(1, DW'(i), 0);
    check_val("fill511_count", 32'(count), 32'd511);
    check_val("fill511_ah",    32'(above_half), 32'd0);
    step(1, DW'(511), 0);
    check_val("fill512_count", 32'(count), 32'd512);
    check_val("fill512_ah",    32'(above_half), 32'd1);

    // stream: reader tied to the enable, one write per cycle
    seq = DW'(512);
    for (int i = 0; i < 600; i++) begin
      step(1, seq, m_stream);
      seq++;
    end
    check_val("stream_count", 32'(count), 32'd512);
    check_val("stream_udf",   32'(underflow), 32'd0);
    check_val("stream_ovf",   32'(overflow), 32'd0);

    // drain, then one more read trips underflow and re-arms
    for (int i = 0; i < HALF; i++) step(0, '0, 1);
    check_val("drain_empty", 32'(empty), 32'd1);
    check_val("drain_ah",    32'(above_half), 32'd1);
    step(0, '0, 1);
    check_val("udf_flag", 32'(underflow), 32'd1);
    check_val("udf_ah",   32'(above_half), 32'd0);
    for (int i = 0; i < HALF; i++) begin
      step(1, seq, 0);
      seq++;
    end
    check_val("refill_ah", 32'(above_half), 32'd1);

    // overflow, boundary simultaneous accesses, read-back order
    reset_step(0, 0);
    for (int i = 0; i < 1030; i++) step(1, DW'(i), 0);
    check_val("ovf_full",  32'(full), 32'd1);
    check_val("ovf_flag",  32'(overflow), 32'd1);
    check_val("ovf_count", 32'(count), 32'd1024);
    step(1, DW'(777), 1);
    check_val("full_rw_count", 32'(count), 32'd1023);
    check_val("full_rw_dout",  32'(dout), 32'd0);
    for (int i = 1; i < DEPTH; i++) step(0, '0, 1);
    check_val("readback_last", 32'(dout), 32'd1023);
    check_val("readback_empty", 32'(empty), 32'd1);
    step(1, DW'(55), 1);
    check_val("empty_rw_count", 32'(count), 32'd1);
    check_val("empty_rw_dv",    32'(dout_valid), 32'd0);

    // randomized traffic in segments of varying read/write pressure
    reset_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int s = 0; s < 15; s++) begin
      pw = $urandom_range(10, 100);
      pr = $urandom_range(0, 100);
      for (int i = 0; i < 200; i++)
        step($urandom_range(0, 99) < pw, DW'($urandom), $urandom_range(0, 99) < pr);
    end

    // reset while streaming with count=300
    reset_step(0, 0);
    for (int i = 0; i < HALF; i++) step(1, DW'(i + 100), 0);
    for (int i = 0; i < 212; i++) step(0, '0, 1);
    check_val("mid_count", 32'(count), 32'd300);
    check_val("mid_ah",    32'(above_half), 32'd1);
    reset_step(1, 1);
    check_val("rst_count", 32'(count), 32'd0);
    check_val("rst_ah",    32'(above_half), 32'd0);
    check_val("rst_dout",  32'(dout), 32'd0);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
